// File: rtl/uart_core.sv
// uart_core: parametrised UART with 16x oversampling, optional parity, 1/2 stop bits and TX/RX FIFOs
module uart_fifo #(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt[AW];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wp] <= din;
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_core #(
  parameter int CLK_DIV    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 PC_Uart_rxd,
  output logic                 PC_Uart_txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 err_clr
);
  localparam int DW = $clog2(CLK_DIV);
  localparam bit ODD = PARITY == 1;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK} rx_state_t;
  tx_state_t ts, ts_n;
  rx_state_t rs, rs_n;
  logic [DW-1:0] tdiv, rdiv;
  logic [4:0] tcnt;
  logic [3:0] rcnt;
  logic [2:0] tbit, rbit;
  logic [DATA_BITS-1:0] tsh, tx_head, rsh, rx_head;
  logic tpar, ttick, tend, tx_empty, t_pop;
  logic s1, rxs, rxs_q, rtick, rmid, rperr, r_done, r_ferr, rx_full;
  uart_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_txf (
    .sysclk(sysclk), .reset(reset), .push(tx_wr), .pop(t_pop), .din(tx_data),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );
  uart_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_rxf (
    .sysclk(sysclk), .reset(reset), .push(r_done && !r_ferr), .pop(rx_rd), .din(rsh),
    .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );
  assign rx_data = rx_empty ? '0 : rx_head;
  assign ttick = tdiv == DW'(CLK_DIV - 1);
  assign tend = ttick && tcnt == ((ts == T_STOP) ? 5'(16 * STOP_BITS - 1) : 5'd15);
  assign rtick = rdiv == DW'(CLK_DIV - 1);
  assign rmid = rtick && rcnt == 4'd7;
  always_comb begin
    ts_n = ts;
    t_pop = 1'b0;
    case (ts)
      T_IDLE: if (!tx_empty) begin
        t_pop = 1'b1;
        ts_n = T_START;
      end
      T_START: if (tend) ts_n = T_DATA;
      T_DATA: if (tend && tbit == 3'(DATA_BITS - 1)) ts_n = (PARITY != 0) ? T_PAR : T_STOP;
      T_PAR: if (tend) ts_n = T_STOP;
      T_STOP: if (tend) begin
        t_pop = !tx_empty;
        ts_n = tx_empty ? T_IDLE : T_START;
      end
      default: ts_n = T_IDLE;
    endcase
  end
  always_ff @(posedge sysclk) ts <= !reset ? T_IDLE : ts_n;
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      tdiv <= '0;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
      tpar <= 1'b0;
      PC_Uart_txd <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      PC_Uart_txd <= (ts == T_START) ? 1'b0 : (ts == T_DATA) ? tsh[0] : (ts == T_PAR) ? tpar : 1'b1;
      tx_busy <= ts != T_IDLE;
      if (t_pop) begin
        tdiv <= '0;
        tcnt <= '0;
        tbit <= '0;
        tsh <= tx_head;
        tpar <= ^tx_head ^ ODD;
      end else begin
        tdiv <= ttick ? '0 : tdiv + DW'(1);
        if (ttick) tcnt <= tend ? '0 : tcnt + 5'd1;
        if (tend && ts == T_DATA) begin
          tbit <= tbit + 3'd1;
          tsh <= tsh >> 1;
        end
      end
    end
  end
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE: if (rxs_q && !rxs) rs_n = R_START;
      R_START: if (rmid) rs_n = rxs ? R_IDLE : R_DATA;
      R_DATA: if (rmid && rbit == 3'(DATA_BITS - 1)) rs_n = (PARITY != 0) ? R_PAR : R_STOP;
      R_PAR: if (rmid) rs_n = R_STOP;
      R_STOP: if (rmid) rs_n = rxs ? R_IDLE : R_BREAK;
      R_BREAK: if (rxs) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge sysclk) rs <= !reset ? R_IDLE : rs_n;
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_q <= 1'b1;
      rdiv <= '0;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      rperr <= 1'b0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      s1 <= PC_Uart_rxd;
      rxs <= s1;
      rxs_q <= rxs;
      if (rs == R_IDLE) begin
        rdiv <= '0;
        rcnt <= '0;
        rbit <= '0;
        rperr <= 1'b0;
      end else begin
        rdiv <= rtick ? '0 : rdiv + DW'(1);
        if (rtick) rcnt <= rcnt + 4'd1;
        if (rmid && rs == R_DATA) begin
          rsh <= {rxs, rsh[DATA_BITS-1:1]};
          rbit <= rbit + 3'd1;
        end
        if (rmid && rs == R_PAR) rperr <= rxs != (^rsh ^ ODD);
      end
      r_done <= rmid && rs == R_STOP;
      r_ferr <= !rxs;
      rx_frame_err <= (rx_frame_err && !err_clr) || (r_done && r_ferr);
      rx_parity_err <= (rx_parity_err && !err_clr) || (r_done && !r_ferr && rperr);
      rx_overrun <= (rx_overrun && !err_clr) || (r_done && !r_ferr && rx_full);
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core against a frame-level reference model
module tb_uart_core;
  localparam int BIT = 64;
  logic sysclk = 1'b0, reset = 1'b0, loop = 1'b0, line0 = 1'b1, line1 = 1'b1;
  logic rxd0, txd0, txd1;
  logic [7:0] tx_data0 = '0, tx_data1 = '0, rx_data0, rx_data1;
  logic tx_wr0 = 1'b0, tx_wr1 = 1'b0, rx_rd0 = 1'b0, rx_rd1 = 1'b0, err_clr0 = 1'b0, err_clr1 = 1'b0;
  logic tx_full0, tx_full1, tx_busy0, tx_busy1, rx_empty0, rx_empty1;
  logic fe0, fe1, pe0, pe1, ov0, ov1;
  int checks = 0, passes = 0, fails = 0;
  logic [7:0] q0[$], q1[$];
  logic mfe[2], mpe[2], mov[2];
  logic [7:0] lb[4], sent[6];
  assign rxd0 = loop ? txd0 : line0;
  always #5 sysclk = ~sysclk;
  uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sysclk(sysclk), .reset(reset), .PC_Uart_rxd(rxd0), .PC_Uart_txd(txd0),
    .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0), .tx_busy(tx_busy0),
    .rx_data(rx_data0), .rx_rd(rx_rd0), .rx_empty(rx_empty0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ov0), .err_clr(err_clr0)
  );
  uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .sysclk(sysclk), .reset(reset), .PC_Uart_rxd(line1), .PC_Uart_txd(txd1),
    .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1), .tx_busy(tx_busy1),
    .rx_data(rx_data1), .rx_rd(rx_rd1), .rx_empty(rx_empty1),
    .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ov1), .err_clr(err_clr1)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_line(input int w, input logic b);
    if (w == 0) line0 = b;
    else line1 = b;
  endtask
  task automatic send(input int w, input logic [7:0] d, input logic par_ok, input logic stop);
    int n;
    set_line(w, 1'b0);
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      set_line(w, d[i]);
      tick(BIT);
    end
    if (w == 1) begin
      set_line(w, par_ok ? ^d : ~^d);
      tick(BIT);
    end
    set_line(w, stop);
    tick(BIT);
    n = (w == 0) ? q0.size() : q1.size();
    if (!stop) mfe[w] = 1'b1;
    else begin
      if (w == 1 && !par_ok) mpe[w] = 1'b1;
      if (n == 4) mov[w] = 1'b1;
      else if (w == 0) q0.push_back(d);
      else q1.push_back(d);
    end
    tick(4);
  endtask
  task automatic pop(input int w);
    if (w == 0) rx_rd0 = 1'b1;
    else rx_rd1 = 1'b1;
    tick(1);
    rx_rd0 = 1'b0;
    rx_rd1 = 1'b0;
  endtask
  task automatic drain(input int w);
    logic [7:0] e;
    while (((w == 0) ? q0.size() : q1.size()) > 0) begin
      if (w == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk("rx_data", (w == 0) ? rx_data0 : rx_data1, e);
      pop(w);
    end
    chk("rx_empty_after_drain", (w == 0) ? rx_empty0 : rx_empty1, 1);
  endtask
  task automatic chk_flags(input string tag, input int w);
    chk(tag, (w == 0) ? {fe0, pe0, ov0} : {fe1, pe1, ov1}, {mfe[w], mpe[w], mov[w]});
  endtask
  task automatic clr(input int w);
    if (w == 0) err_clr0 = 1'b1;
    else err_clr1 = 1'b1;
    tick(1);
    err_clr0 = 1'b0;
    err_clr1 = 1'b0;
    mfe[w] = 1'b0;
    mpe[w] = 1'b0;
    mov[w] = 1'b0;
  endtask
  function automatic logic exp_txd(input int k);
    int f = k / (10 * BIT), p = (k % (10 * BIT)) / BIT;
    if (f >= 4) return 1'b1;
    return (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : lb[f][p-1];
  endfunction
  initial begin
    int errs, got;
    for (int i = 0; i < 2; i++) begin
      mfe[i] = 1'b0;
      mpe[i] = 1'b0;
      mov[i] = 1'b0;
    end
    lb = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    tick(3);
    chk("rst_txd", txd0, 1);
    chk("rst_tx_full", tx_full0, 0);
    chk("rst_tx_busy", tx_busy0, 0);
    chk("rst_rx_empty", rx_empty0, 1);
    chk("rst_rx_data", rx_data0, 0);
    chk_flags("rst_flags", 0);
    chk("rst_rx_empty_par", rx_empty1, 1);
    reset = 1'b1;
    tick(2);
    loop = 1'b1;
    tx_wr0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data0 = lb[i];
      tick(1);
      if (i == 1) chk("tx_latency_idle", txd0, 1);
      if (i == 2) begin
        chk("tx_latency_start", txd0, 0);
        chk("tx_latency_busy", tx_busy0, 1);
      end
    end
    tx_wr0 = 1'b0;
    errs = 0;
    for (int k = 1; k < 2600; k++) begin
      if (txd0 !== exp_txd(k)) errs++;
      tick(1);
    end
    chk("tx_waveform", errs, 0);
    chk("tx_busy_done", tx_busy0, 0);
    for (int i = 0; i < 4; i++) q0.push_back(lb[i]);
    drain(0);
    chk_flags("loop_flags", 0);
    loop = 1'b0;
    send(0, 8'h81, 1'b1, 1'b0);
    tick(200);
    chk("break_no_push", rx_empty0, 1);
    chk_flags("frame_err", 0);
    set_line(0, 1'b1);
    tick(BIT);
    send(0, 8'h42, 1'b1, 1'b1);
    chk("after_break_data", rx_data0, 8'h42);
    drain(0);
    clr(0);
    chk_flags("frame_clr", 0);
    for (int i = 0; i < 5; i++) send(0, 8'($urandom), 1'b1, 1'b1);
    chk_flags("overrun", 0);
    drain(0);
    pop(0);
    chk("rd_empty_ignored", rx_empty0, 1);
    chk("rd_empty_data", rx_data0, 0);
    send(0, 8'($urandom), 1'b1, 1'b1);
    drain(0);
    clr(0);
    loop = 1'b1;
    tx_wr0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sent[i] = 8'($urandom);
      tx_data0 = sent[i];
      tick(1);
      if (i == 3) chk("tx_not_full", tx_full0, 0);
      if (i == 4) chk("tx_full", tx_full0, 1);
    end
    tx_wr0 = 1'b0;
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!rx_empty0) begin
        if (got < 5) chk("tx_fifo_data", rx_data0, sent[got]);
        got++;
        pop(0);
      end else tick(1);
    end
    chk("tx_fifo_count", got, 5);
    chk_flags("tx_fifo_flags", 0);
    loop = 1'b0;
    set_line(0, 1'b0);
    tick(20);
    set_line(0, 1'b1);
    tick(700);
    chk("glitch_no_push", rx_empty0, 1);
    chk_flags("glitch_flags", 0);
    tx_data0 = 8'($urandom);
    tx_wr0 = 1'b1;
    tick(1);
    tx_wr0 = 1'b0;
    tick(200);
    chk("mid_frame_busy", tx_busy0, 1);
    reset = 1'b0;
    tick(1);
    chk("rst_mid_txd", txd0, 1);
    chk("rst_mid_busy", tx_busy0, 0);
    chk("rst_mid_full", tx_full0, 0);
    reset = 1'b1;
    tick(100);
    chk("post_rst_txd", txd0, 1);
    chk("post_rst_busy", tx_busy0, 0);
    send(1, 8'h55, 1'b0, 1'b1);
    chk_flags("parity_err", 1);
    drain(1);
    clr(1);
    chk_flags("parity_clr", 1);
    for (int i = 0; i < 3; i++) send(1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    chk_flags("parity_rand", 1);
    drain(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
